// File: rtl/mpi_eth_pkg.sv
// Shared types for the MPI-over-Ethernet header parser: FSM states, the header
// record, header bit offsets and the final-beat keep mask helper.
package mpi_eth_pkg;

  typedef enum logic [2:0] {
    ST_HDR0    = 3'd0,
    ST_HDR1    = 3'd1,
    ST_HDR2    = 3'd2,
    ST_HDR3    = 3'd3,
    ST_HDR_OUT = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_DROP    = 3'd6
  } state_t;

  typedef struct packed {
    logic [47:0] mac_dst;
    logic [15:0] dst;
    logic [47:0] mac_src;
    logic [15:0] dst_rank;
    logic [31:0] ip_dst;
    logic [31:0] ip_src;
    logic [7:0]  src_rank;
    logic [7:0]  packet_type;
    logic [31:0] size;
    logic [7:0]  tag;
    logic        last;
  } hdr_t;

  localparam int HDR_BEATS    = 4;
  localparam int MAC_LSB      = 16;
  localparam int IP_DST_LSB   = 32;
  localparam int SRC_RANK_LSB = 56;
  localparam int TYPE_LSB     = 48;
  localparam int SIZE_LSB     = 16;
  localparam int TAG_LSB      = 8;
  localparam int LAST_BIT     = 0;

  // Contiguous low-byte mask for a final beat holding n bytes; n=0 means a full beat.
  function automatic logic [7:0] keep_mask(input logic [2:0] n);
    case (n)
      3'd1:    keep_mask = 8'h01;
      3'd2:    keep_mask = 8'h03;
      3'd3:    keep_mask = 8'h07;
      3'd4:    keep_mask = 8'h0F;
      3'd5:    keep_mask = 8'h1F;
      3'd6:    keep_mask = 8'h3F;
      3'd7:    keep_mask = 8'h7F;
      default: keep_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mpi_eth_hdr_parser_axis_reg_slice.sv
// Single-stage AXI-stream register slice (64-bit data + keep + last); full
// throughput because a new beat is accepted in the cycle the held one drains.
module axis_reg_slice (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [63:0] i_data,
  input  logic [7:0]  i_keep,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic [7:0]  o_keep,
  output logic        o_last,
  input  logic        i_out_ready
);

  logic        r_valid;
  logic [63:0] r_data;
  logic [7:0]  r_keep;
  logic        r_last;

  assign o_ready = !r_valid || i_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_keep <= i_keep;
        r_last <= i_last;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_last  = r_last;

endmodule

// File: rtl/mpi_eth_hdr_parser.sv
// MPI/Ethernet ingress header parser: 4-beat header to registered fields, payload
// through a register slice. Optional MPI_HDR_PARSER_LEN_CHECK_EN enables size-vs-LAST checks.
// Handshake: a beat transfers on any rising edge where VALID && READY; VALID never
// waits on READY, and a VALID source holds its payload until the transfer.
module mpi_eth_hdr_parser
  import mpi_eth_pkg::*;
#(
  parameter int MAX_SIZE  = 9000,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          stream_in_DATA,
  input  logic [7:0]           stream_in_KEEP,
  input  logic                 stream_in_LAST,
  input  logic                 stream_in_VALID,
  output logic                 stream_in_READY,
  output logic [63:0]          stream_out_DATA,
  output logic [7:0]           stream_out_KEEP,
  output logic                 stream_out_LAST,
  output logic                 stream_out_VALID,
  input  logic                 stream_out_READY,
  output logic [47:0]          mac_dst,
  output logic [47:0]          mac_src,
  output logic [15:0]          dst,
  output logic [15:0]          dst_rank,
  output logic [7:0]           src_rank,
  output logic [7:0]           packet_type,
  output logic [7:0]           tag,
  output logic [31:0]          size,
  output logic [31:0]          ip_dst,
  output logic [31:0]          ip_src,
  output logic                 last,
  output logic                 hdr_valid,
  input  logic                 hdr_ready,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [2:0]           dbg_state
);

  state_t               r_state, w_next;
  logic [63:0]          r_b0, r_b1, r_b2;
  hdr_t                 r_hdr, w_hdr_new;
  logic                 r_hdr_valid;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic        w_in_ready, w_slice_ready, w_s_valid, w_s_last;
  logic [7:0]  w_s_keep;
  logic        w_err, w_hdr_load, w_pay_fire, w_has_payload;
  logic        w_hdr_bad, w_beat3_bad, w_is_last_hdr;
  logic [1:0]  w_beat_idx;
  logic [31:0] w_size;

`ifdef MPI_HDR_PARSER_LEN_CHECK_EN
  logic [32:0] r_beats_left;
  logic [32:0] w_beats;
  logic        w_final;
  assign w_beats       = ({1'b0, w_size} + 33'd7) >> 3;
  assign w_final       = (r_beats_left == 33'd1);
  assign w_has_payload = (r_hdr.size != 32'd0);
  assign w_beat3_bad   = (w_size > 32'(MAX_SIZE)) || (stream_in_LAST != (w_size == 32'd0));
`else
  // Without length checks, beat-3 LAST alone decides whether a payload follows.
  logic r_beat3_last;
  assign w_has_payload = !r_beat3_last;
  assign w_beat3_bad   = (w_size > 32'(MAX_SIZE));
`endif

  assign w_beat_idx    = r_state[1:0];
  assign w_is_last_hdr = (int'(w_beat_idx) == HDR_BEATS - 1);
  assign w_size        = stream_in_DATA[SIZE_LSB +: 32];
  assign w_hdr_bad     = (stream_in_KEEP != 8'hFF) ||
                         (w_is_last_hdr ? w_beat3_bad : stream_in_LAST);

  always_comb begin
    w_hdr_new.mac_dst     = r_b0[63:MAC_LSB];
    w_hdr_new.dst         = r_b0[15:0];
    w_hdr_new.mac_src     = r_b1[63:MAC_LSB];
    w_hdr_new.dst_rank    = r_b1[15:0];
    w_hdr_new.ip_dst      = r_b2[IP_DST_LSB +: 32];
    w_hdr_new.ip_src      = r_b2[31:0];
    w_hdr_new.src_rank    = stream_in_DATA[SRC_RANK_LSB +: 8];
    w_hdr_new.packet_type = stream_in_DATA[TYPE_LSB +: 8];
    w_hdr_new.size        = w_size;
    w_hdr_new.tag         = stream_in_DATA[TAG_LSB +: 8];
    w_hdr_new.last        = stream_in_DATA[LAST_BIT];
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_s_valid  = 1'b0;
    w_s_last   = stream_in_LAST;
    w_s_keep   = stream_in_KEEP;
    w_err      = 1'b0;
    w_hdr_load = 1'b0;
    w_pay_fire = 1'b0;
    case (r_state)
      ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3: begin
        w_in_ready = 1'b1;
        if (stream_in_VALID) begin
          // An errored beat that already carries LAST ends the packet here.
          if (w_hdr_bad) begin
            w_err  = 1'b1;
            w_next = stream_in_LAST ? ST_HDR0 : ST_DROP;
          end else if (w_is_last_hdr) begin
            w_hdr_load = 1'b1;
            w_next     = ST_HDR_OUT;
          end else begin
            w_next = state_t'({1'b0, w_beat_idx + 2'd1});
          end
        end
      end
      ST_HDR_OUT: begin
        if (hdr_ready) w_next = w_has_payload ? ST_PAYLOAD : ST_HDR0;
      end
      ST_PAYLOAD: begin
        w_in_ready = w_slice_ready;
        w_s_valid  = stream_in_VALID;
        if (stream_in_VALID && w_slice_ready) begin
          w_pay_fire = 1'b1;
`ifdef MPI_HDR_PARSER_LEN_CHECK_EN
          if (w_final) begin
            w_s_last = 1'b1;
            w_s_keep = keep_mask(r_hdr.size[2:0]);
            w_err    = !stream_in_LAST;
            w_next   = stream_in_LAST ? ST_HDR0 : ST_DROP;
          end else if (stream_in_LAST) begin
            w_err  = 1'b1;
            w_next = ST_HDR0;
          end
`else
          if (stream_in_LAST) w_next = ST_HDR0;
`endif
        end
      end
      ST_DROP: begin
        w_in_ready = 1'b1;
        if (stream_in_VALID && stream_in_LAST) w_next = ST_HDR0;
      end
      default: w_next = ST_HDR0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_HDR0;
      r_b0         <= '0;
      r_b1         <= '0;
      r_b2         <= '0;
      r_hdr        <= '0;
      r_hdr_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= '0;
`ifdef MPI_HDR_PARSER_LEN_CHECK_EN
      r_beats_left <= '0;
`else
      r_beat3_last <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      if (stream_in_VALID) begin
        if (r_state == ST_HDR0) r_b0 <= stream_in_DATA;
        if (r_state == ST_HDR1) r_b1 <= stream_in_DATA;
        if (r_state == ST_HDR2) r_b2 <= stream_in_DATA;
      end
      if (w_hdr_load) begin
        r_hdr       <= w_hdr_new;
        r_hdr_valid <= 1'b1;
      end else if ((r_state == ST_HDR_OUT) && hdr_ready) begin
        r_hdr_valid <= 1'b0;
      end
`ifdef MPI_HDR_PARSER_LEN_CHECK_EN
      if (w_hdr_load)      r_beats_left <= w_beats;
      else if (w_pay_fire) r_beats_left <= r_beats_left - 33'd1;
`else
      if (w_hdr_load) r_beat3_last <= stream_in_LAST;
`endif
    end
  end

  axis_reg_slice u_slice (
    .clk         (clk),
    .rst         (reset),
    .i_valid     (w_s_valid),
    .i_data      (stream_in_DATA),
    .i_keep      (w_s_keep),
    .i_last      (w_s_last),
    .o_ready     (w_slice_ready),
    .o_valid     (stream_out_VALID),
    .o_data      (stream_out_DATA),
    .o_keep      (stream_out_KEEP),
    .o_last      (stream_out_LAST),
    .i_out_ready (stream_out_READY)
  );

  assign stream_in_READY = w_in_ready;
  assign mac_dst     = r_hdr.mac_dst;
  assign mac_src     = r_hdr.mac_src;
  assign dst         = r_hdr.dst;
  assign dst_rank    = r_hdr.dst_rank;
  assign src_rank    = r_hdr.src_rank;
  assign packet_type = r_hdr.packet_type;
  assign tag         = r_hdr.tag;
  assign size        = r_hdr.size;
  assign ip_dst      = r_hdr.ip_dst;
  assign ip_src      = r_hdr.ip_src;
  assign last        = r_hdr.last;
  assign hdr_valid   = r_hdr_valid;
  assign err         = r_err;
  assign err_cnt     = r_err_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mpi_eth_hdr_parser.sv
// Table-driven bench for mpi_eth_hdr_parser: packet vectors with hand-computed
// expectations, plus header back-pressure, late-LAST and mid-packet reset sequences.
module tb_mpi_eth_hdr_parser;
  import mpi_eth_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] stream_in_DATA;
  logic [7:0]  stream_in_KEEP;
  logic        stream_in_LAST, stream_in_VALID, stream_in_READY;
  logic [63:0] stream_out_DATA;
  logic [7:0]  stream_out_KEEP;
  logic        stream_out_LAST, stream_out_VALID;
  logic        stream_out_READY = 1'b1;
  logic [47:0] mac_dst, mac_src;
  logic [15:0] dst, dst_rank;
  logic [7:0]  src_rank, packet_type, tag;
  logic [31:0] size, ip_dst, ip_src;
  logic        last, hdr_valid, hdr_ready, err;
  logic [15:0] err_cnt;
  logic [2:0]  dbg_state;

  mpi_eth_hdr_parser dut (
    .clk(clk), .reset(reset),
    .stream_in_DATA(stream_in_DATA), .stream_in_KEEP(stream_in_KEEP),
    .stream_in_LAST(stream_in_LAST), .stream_in_VALID(stream_in_VALID),
    .stream_in_READY(stream_in_READY),
    .stream_out_DATA(stream_out_DATA), .stream_out_KEEP(stream_out_KEEP),
    .stream_out_LAST(stream_out_LAST), .stream_out_VALID(stream_out_VALID),
    .stream_out_READY(stream_out_READY),
    .mac_dst(mac_dst), .mac_src(mac_src), .dst(dst), .dst_rank(dst_rank),
    .src_rank(src_rank), .packet_type(packet_type), .tag(tag), .size(size),
    .ip_dst(ip_dst), .ip_src(ip_src), .last(last),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .err(err), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [47:0] mac_dst;
    logic [15:0] dst;
    logic [47:0] mac_src;
    logic [15:0] dst_rank;
    logic [31:0] ip_dst;
    logic [31:0] ip_src;
    logic [7:0]  src_rank;
    logic [7:0]  ptype;
    logic [31:0] size;
    logic [7:0]  tag;
    logic        lastf;
    logic [7:0]  keep1;
    int          n_pay;
    logic [7:0]  last_keep;
    logic        exp_hdr;
    int          exp_err;
    logic        tog;
  } vec_t;

  vec_t vecs[9];
  logic [72:0]  exp_q[$];
  logic [248:0] hq[$];
  int checks = 0;
  int failures = 0;
  int exp_errs = 0;
  int err_seen = 0;
  int rdy_mode = 0;
  logic [72:0]  got_beat, exp_beat;
  logic [248:0] got_hdr, exp_hdr_v;

  function automatic logic [63:0] pay_data(input int id, input int i);
    return {id[31:0], i[31:0]};
  endfunction

  function automatic logic [248:0] hdr_of(input vec_t v);
    return {v.mac_dst, v.dst, v.mac_src, v.dst_rank, v.ip_dst, v.ip_src,
            v.src_rank, v.ptype, v.size, v.tag, v.lastf};
  endfunction

  function automatic vec_t mk(input int id, input logic [31:0] sz, input int n_pay,
                              input logic [7:0] last_keep, input logic [7:0] keep1,
                              input logic exp_hdr, input int exp_err, input logic tog);
    vec_t v;
    v.mac_dst = 48'h0A0B0C0D0E0F; v.dst = 16'(id + 1);
    v.mac_src = 48'h112233445566; v.dst_rank = 16'd3;
    v.ip_dst = 32'hC0A80001; v.ip_src = 32'hC0A80002;
    v.src_rank = 8'd1; v.ptype = 8'd2; v.size = sz; v.tag = 8'(id + 7);
    v.lastf = id[0]; v.keep1 = keep1; v.n_pay = n_pay; v.last_keep = last_keep;
    v.exp_hdr = exp_hdr; v.exp_err = exp_err; v.tog = tog;
    return v;
  endfunction

  // ---------------- drivers ----------------
  initial forever begin
    @(posedge clk); #2;
    case (rdy_mode)
      0:       stream_out_READY = 1'b1;
      1:       stream_out_READY = ~stream_out_READY;
      default: stream_out_READY = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    logic acc;
    @(negedge clk);
    stream_in_DATA = d; stream_in_KEEP = k; stream_in_LAST = l; stream_in_VALID = 1'b1;
    forever begin
      #1 acc = stream_in_READY;
      @(posedge clk);
      if (acc) break;
      n++;
      if (n > 1000) begin
        checks++; failures++;
        $display("FAIL send_timeout data=%0h", d);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    stream_in_VALID = 1'b0; stream_in_LAST = 1'b0;
  endtask

  task automatic send_pkt(input vec_t v, input int id, input int n_send, input bit push);
    logic [63:0] b[4];
    logic        lst;
    b[0] = {v.mac_dst, v.dst};
    b[1] = {v.mac_src, v.dst_rank};
    b[2] = {v.ip_dst, v.ip_src};
    b[3] = {v.src_rank, v.ptype, v.size, v.tag, 7'd0, v.lastf};
    if (v.exp_hdr) hq.push_back(hdr_of(v));
    if (push && v.exp_hdr)
      for (int i = 0; i < v.n_pay; i++) begin
        lst = (i == v.n_pay - 1);
        exp_q.push_back({lst, lst ? v.last_keep : 8'hFF, pay_data(id, i)});
      end
    for (int k = 0; k < 4; k++)
      send_beat(b[k], (k == 1) ? v.keep1 : 8'hFF, (k == 3) && (v.n_pay == 0));
    #1 chk("hdr_valid_latency", 64'(hdr_valid), 64'(v.exp_hdr));
    for (int i = 0; i < n_send; i++)
      send_beat(pay_data(id, i), (i == v.n_pay - 1) ? v.last_keep : 8'hFF, i == v.n_pay - 1);
    idle();
  endtask

  task automatic drain_and_check();
    int n = 0;
    while ((exp_q.size() != 0 || hq.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_pending", 64'(exp_q.size() + hq.size()), 64'd0);
    chk("err_cnt", 64'(err_cnt), 64'(exp_errs));
    chk("err_pulses", 64'(err_seen), 64'(exp_errs));
    chk("state_idle", 64'(dbg_state), 64'(ST_HDR0));
  endtask

  task automatic run_vec(input int i);
    rdy_mode = vecs[i].tog ? 1 : 0;
    send_pkt(vecs[i], i, vecs[i].n_pay, 1'b1);
    exp_errs += vecs[i].exp_err;
    drain_and_check();
    rdy_mode = 0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (stream_out_VALID && stream_out_READY) begin
        checks++;
        got_beat = {stream_out_LAST, stream_out_KEEP, stream_out_DATA};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL payload_unexpected got=%0h", got_beat);
        end else begin
          exp_beat = exp_q.pop_front();
          if (got_beat !== exp_beat) begin
            failures++;
            $display("FAIL payload_beat got=%0h exp=%0h", got_beat, exp_beat);
          end
        end
      end
      if (hdr_valid && hdr_ready) begin
        checks++;
        got_hdr = {mac_dst, dst, mac_src, dst_rank, ip_dst, ip_src,
                   src_rank, packet_type, size, tag, last};
        if (hq.size() == 0) begin
          failures++;
          $display("FAIL header_unexpected got=%0h", got_hdr);
        end else begin
          exp_hdr_v = hq.pop_front();
          if (got_hdr !== exp_hdr_v) begin
            failures++;
            $display("FAIL header_fields got=%0h exp=%0h", got_hdr, exp_hdr_v);
          end
        end
      end
      if (err) err_seen++;
    end
  end

  // ---------------- test ----------------
  initial begin
    vec_t v;
    int   n;
    vecs[0] = mk(0, 32'd20,   3,    8'h0F, 8'hFF, 1'b1, 0, 1'b0);
    vecs[1] = mk(1, 32'd0,    0,    8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    vecs[2] = mk(2, 32'd16,   2,    8'hFF, 8'h7F, 1'b0, 1, 1'b0);
    vecs[3] = mk(3, 32'd8,    1,    8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    vecs[4] = mk(4, 32'd9001, 2,    8'hFF, 8'hFF, 1'b0, 1, 1'b0);
    vecs[5] = mk(5, 32'd9000, 1125, 8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    vecs[6] = mk(6, 32'd512,  64,   8'hFF, 8'hFF, 1'b1, 0, 1'b1);
`ifdef MPI_HDR_PARSER_LEN_CHECK_EN
    vecs[7] = mk(7, 32'd24,   2,    8'hFF, 8'hFF, 1'b1, 1, 1'b0);
`else
    vecs[7] = mk(7, 32'd24,   2,    8'hFF, 8'hFF, 1'b1, 0, 1'b0);
`endif
    vecs[8] = mk(8, 32'd13,   2,    8'h1F, 8'hFF, 1'b1, 0, 1'b0);

    reset = 1'b1; hdr_ready = 1'b1;
    stream_in_DATA = '0; stream_in_KEEP = '0; stream_in_LAST = 1'b0; stream_in_VALID = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    chk("rst_out_valid", 64'(stream_out_VALID), 64'd0);
    chk("rst_out_data", stream_out_DATA, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_mac_dst", 64'(mac_dst), 64'd0);
    chk("rst_size", 64'(size), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_HDR0));
    chk("rst_in_ready", 64'(stream_in_READY), 64'd1);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Header held: no input accepted and no payload until hdr_ready returns.
    @(posedge clk); #2 hdr_ready = 1'b0;
    fork
      send_pkt(vecs[0], 20, 3, 1'b1);
      begin
        n = 0;
        while (!hdr_valid && n < 100) begin @(negedge clk); n++; end
        chk("hold_hdr_valid", 64'(hdr_valid), 64'd1);
        repeat (10) begin
          @(negedge clk);
          chk("hold_in_ready", 64'(stream_in_READY), 64'd0);
          chk("hold_no_payload", 64'(stream_out_VALID), 64'd0);
        end
        @(posedge clk); #2 hdr_ready = 1'b1;
      end
    join
    drain_and_check();

    // size=8 but LAST only on the second payload beat.
    v = vecs[3];
    v.n_pay = 2;
`ifdef MPI_HDR_PARSER_LEN_CHECK_EN
    exp_q.push_back({1'b1, 8'hFF, pay_data(30, 0)});
    exp_errs++;
`else
    exp_q.push_back({1'b0, 8'hFF, pay_data(30, 0)});
    exp_q.push_back({1'b1, 8'hFF, pay_data(30, 1)});
`endif
    send_pkt(v, 30, 2, 1'b0);
    drain_and_check();

    // Reset mid-packet with a payload beat stuck in the slice.
    rdy_mode = 2;
    send_pkt(vecs[0], 40, 1, 1'b1);
    @(negedge clk);
    chk("held_beat_valid", 64'(stream_out_VALID), 64'd1);
    chk("held_beat_data", stream_out_DATA, pay_data(40, 0));
    reset = 1'b1;
    exp_q.delete(); hq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rdy_mode = 0; exp_errs = 0; err_seen = 0;
    #1;
    chk("mid_rst_out_valid", 64'(stream_out_VALID), 64'd0);
    chk("mid_rst_hdr_valid", 64'(hdr_valid), 64'd0);
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("mid_rst_size", 64'(size), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'(ST_HDR0));
    run_vec(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
